disp_num_fmt: RTL and testbench
===============================

// Module: disp_num_fmt
// PURPOSE
//  Sequential binary->decimal formatter feeding the character LCD display stage.
//  Accepts one unsigned measurement (freq/duty/stat), converts it by double-dabble,
//  applies leading-zero blanking and an optional fixed decimal point, and emits
//  ready-to-send LCD data words (RS=1,RW=0,ASCII) as indexed writes into the display
//  character buffer. One instance per displayed field.
// PARAMETERS
//  VAL_BITS  11  width of input value
//  DIGITS    4   decimal digits shown (1..6)
//  DP_POS    1   digits right of decimal point (0 = no point, < DIGITS)
//  BLANK_LZ  1   1 = replace leading zeros with SYMBOL_SPACE
//  BASE_ADDR 6   character buffer index of leftmost emitted character
// PORTS
//  clk      in   1         system clock
//  rst      in   1         asynchronous reset, active-high
//  val      in   VAL_BITS  value to format, unsigned, sampled on accept
//  val_vld  in   1         val is valid
//  val_rdy  out  1         block can accept (high only in IDLE)
//  wr_en    out  1         character write strobe, one cycle per character
//  wr_addr  out  6         buffer index of current character
//  wr_data  out  10        LCD data word {2'b10, ascii}
//  busy     out  1         high in CONV and EMIT
//  ovf      out  1         last accepted value exceeded 10^DIGITS-1
// BEHAVIOUR
//  - Reset (async, active-high): state=IDLE, val_rdy=1 after release, wr_en=0,
//    wr_addr=0, wr_data=0, busy=0, ovf=0; any in-progress field is abandoned, no further writes.
//  - Accept: val_vld & val_rdy at rising edge T0 -> val latched, state CONV.
//  - CONV: VAL_BITS cycles of shift/add-3 over DIGITS+1 BCD nibbles (extra nibble detects ovf).
//  - EMIT: NCHR = DIGITS + (DP_POS>0) characters, MSB first, one per cycle;
//    first wr_en on cycle T0+VAL_BITS+1, wr_addr = BASE_ADDR..BASE_ADDR+NCHR-1.
//    After last char -> IDLE; val_rdy high the following cycle. Back-to-back
//    period = VAL_BITS+NCHR+1 cycles.
//  - DP: SYMBOL_DOT inserted after digit DIGITS-DP_POS (counting from left).
//  - Blanking (BLANK_LZ=1): zero digit is SPACE while all digits left of it are
//    zero, except the units digit of the integer part (left of DP, or last digit)
//    which is always shown. BLANK_LZ=0: all digits shown.
//  - Overflow: val > 10^DIGITS-1 -> every digit position emits SYMBOL_MINUS
//    (10'b1000101101), DP still emitted; ovf set at first wr_en, held until next accept.
//  - val_vld high during CONV/EMIT is ignored (not captured, no backpressure loss).
//  - wr_data/wr_addr are registered; valid only while wr_en=1 (hold last value otherwise).
//  - Arithmetic: BCD nibbles 4b each, add-3 when nibble >= 5 before each shift;
//    ascii digit = 8'h30 + nibble.
// STRUCTURE
//  - disp_pkg: lcd_char_t (logic [9:0]); SYMBOL_0..9, SYMBOL_SPACE, SYMBOL_DOT,
//    SYMBOL_MINUS, SYMBOL_COLON, SYMBOL_PERCENT, LCD command constants (clr, home,
//    line_2, entry, onoff); fmt_state_t enum {IDLE, CONV, EMIT}.
//  - Sub-module bin2bcd: sequential double-dabble, start/done handshake,
//    outputs DIGITS+1 nibbles; disp_num_fmt holds FSM, blanking, DP insertion, emit counter.
// TESTING (defaults unless stated)
//  1. val=1207 -> 5 writes addr 6..10: '1','2','0','.','7'; ovf=0; first wr_en at T0+12.
//  2. val=5 -> ' ',' ','0','.','5' (units digit left of DP not blanked).
//  3. DP_POS=0, val=0 -> 4 writes ' ',' ',' ','0'; BLANK_LZ=0, val=0 -> '0','0','0','0'.
//  4. val=2047 with DIGITS=3 -> '-','-','.','-' (NCHR=4) ... ovf=1 until next accept.
//  5. val_vld held high, vals 1207 then 333 -> second accepted one cycle after val_rdy
//     returns; writes never interleave; "033.3" blanked as " 33.3".
//  6. rst asserted during 3rd EMIT char -> wr_en=0 immediately, outputs at reset values;
//     next accept after release produces full, correct 5-char field.

Source files
------------

// File: rtl/disp_num_fmt_pkg.sv
// Shared LCD character encodings and formatter state type for the display field formatters.
package disp_pkg;

    typedef logic [9:0] lcd_char_t;

    // Data words carry RS=1, RW=0 followed by the ASCII code; commands carry RS=0.
    localparam lcd_char_t SYMBOL_0       = 10'h230;
    localparam lcd_char_t SYMBOL_1       = 10'h231;
    localparam lcd_char_t SYMBOL_2       = 10'h232;
    localparam lcd_char_t SYMBOL_3       = 10'h233;
    localparam lcd_char_t SYMBOL_4       = 10'h234;
    localparam lcd_char_t SYMBOL_5       = 10'h235;
    localparam lcd_char_t SYMBOL_6       = 10'h236;
    localparam lcd_char_t SYMBOL_7       = 10'h237;
    localparam lcd_char_t SYMBOL_8       = 10'h238;
    localparam lcd_char_t SYMBOL_9       = 10'h239;
    localparam lcd_char_t SYMBOL_SPACE   = 10'h220;
    localparam lcd_char_t SYMBOL_DOT     = 10'h22E;
    localparam lcd_char_t SYMBOL_MINUS   = 10'h22D;
    localparam lcd_char_t SYMBOL_COLON   = 10'h23A;
    localparam lcd_char_t SYMBOL_PERCENT = 10'h225;

    localparam lcd_char_t LCD_CMD_CLR    = 10'h001;
    localparam lcd_char_t LCD_CMD_HOME   = 10'h002;
    localparam lcd_char_t LCD_CMD_LINE_2 = 10'h0C0;
    localparam lcd_char_t LCD_CMD_ENTRY  = 10'h006;
    localparam lcd_char_t LCD_CMD_ONOFF  = 10'h00C;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        EMIT = 2'd2
    } fmt_state_t;

    function automatic lcd_char_t digit_char(input logic [3:0] nib);
        return {2'b10, 8'h30 + {4'h0, nib}};
    endfunction

endpackage

// File: rtl/disp_num_fmt_bin2bcd.sv
// Sequential double-dabble converter: one shift per cycle, one spare nibble plus a
// sticky carry-out flag so values beyond DIGITS decimal digits are reported as overflow.
module bin2bcd #(
    parameter int VAL_BITS = 11,
    parameter int DIGITS   = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start_i,
    input  logic [VAL_BITS-1:0]       val_i,
    output logic                      done_o,
    output logic [4*(DIGITS+1)-1:0]   bcd_o,
    output logic                      ovf_o
);
    localparam int BW = 4 * (DIGITS + 1);
    localparam int CW = $clog2(VAL_BITS + 1);

    logic [VAL_BITS-1:0] bin_q, bin_d;
    logic [BW-1:0]       bcd_q, bcd_d, adj_s;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                act_q, act_d, lost_q, lost_d;

    // add-3 correction and shift step
    always_comb begin
        adj_s = bcd_q;
        for (int i = 0; i < DIGITS + 1; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                adj_s[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end else begin
                adj_s[4*i +: 4] = bcd_q[4*i +: 4];
            end
        end
        bin_d  = bin_q;
        bcd_d  = bcd_q;
        cnt_d  = cnt_q;
        act_d  = act_q;
        lost_d = lost_q;
        if (start_i) begin
            bin_d  = val_i;
            bcd_d  = {BW{1'b0}};
            cnt_d  = CW'(VAL_BITS);
            act_d  = 1'b1;
            lost_d = 1'b0;
        end else if (act_q && (cnt_q != {CW{1'b0}})) begin
            {bcd_d, bin_d} = {adj_s[BW-2:0], bin_q, 1'b0};
            lost_d         = lost_q | adj_s[BW-1];
            cnt_d          = cnt_q - CW'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // conversion registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_q  <= {VAL_BITS{1'b0}};
            bcd_q  <= {BW{1'b0}};
            cnt_q  <= {CW{1'b0}};
            act_q  <= 1'b0;
            lost_q <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            bcd_q  <= bcd_d;
            cnt_q  <= cnt_d;
            act_q  <= act_d;
            lost_q <= lost_d;
        end
    end

    assign done_o = act_q && (cnt_q == {CW{1'b0}});
    assign bcd_o  = bcd_q;
    assign ovf_o  = lost_q | (bcd_q[BW-1 -: 4] != 4'd0);

endmodule

// File: rtl/disp_num_fmt.sv
// Formats one unsigned measurement into LCD data words (blanking, decimal point,
// overflow dashes) and writes them one per cycle into the display character buffer.
module disp_num_fmt
    import disp_pkg::*;
#(
    parameter int VAL_BITS  = 11,
    parameter int DIGITS    = 4,
    parameter int DP_POS    = 1,
    parameter int BLANK_LZ  = 1,
    parameter int BASE_ADDR = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [VAL_BITS-1:0] val,
    input  logic                val_vld,
    output logic                val_rdy,
    output logic                wr_en,
    output logic [5:0]          wr_addr,
    output logic [9:0]          wr_data,
    output logic                busy,
    output logic                ovf
);
    localparam int         NCHR     = DIGITS + ((DP_POS > 0) ? 1 : 0);
    localparam int         BW       = 4 * (DIGITS + 1);
    localparam logic [2:0] LAST_IDX = 3'(NCHR - 1);
    localparam logic [2:0] DOT_IDX  = 3'(DIGITS - DP_POS);
    localparam logic [2:0] UNIT_DIG = 3'(DIGITS - DP_POS - 1);
    localparam logic [2:0] TOP_NIB  = 3'(DIGITS - 1);

    fmt_state_t state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic       lz_q, lz_d;
    logic       wr_en_q, wr_en_d;
    logic [5:0] wr_addr_q, wr_addr_d;
    lcd_char_t  wr_data_q, wr_data_d;
    logic       ovf_q, ovf_d;

    logic          accept_s, done_s, bcd_ovf_s, emit_s, is_dot_s;
    logic [BW-1:0] bcd_s;
    logic [2:0]    dig_s, nib_idx_s;
    logic [3:0]    nib_s;
    lcd_char_t     char_s;

    assign val_rdy  = (state_q == IDLE);
    assign busy     = (state_q != IDLE);
    assign accept_s = val_vld & val_rdy;
    assign emit_s   = ((state_q == CONV) && done_s) || (state_q == EMIT);
    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign ovf      = ovf_q;

    bin2bcd #(
        .VAL_BITS (VAL_BITS),
        .DIGITS   (DIGITS)
    ) u_bin2bcd (
        .clk     (clk),
        .rst     (rst),
        .start_i (accept_s),
        .val_i   (val),
        .done_o  (done_s),
        .bcd_o   (bcd_s),
        .ovf_o   (bcd_ovf_s)
    );

    // character for the current emit position; only digits left of the units digit blank
    always_comb begin
        is_dot_s = (DP_POS > 0) && (idx_q == DOT_IDX);
        if ((DP_POS > 0) && (idx_q > DOT_IDX)) begin
            dig_s = idx_q - 3'd1;
        end else begin
            dig_s = idx_q;
        end
        nib_idx_s = TOP_NIB - dig_s;
        nib_s     = bcd_s[{nib_idx_s, 2'b00} +: 4];
        if (is_dot_s) begin
            char_s = SYMBOL_DOT;
        end else if (bcd_ovf_s) begin
            char_s = SYMBOL_MINUS;
        end else if ((BLANK_LZ != 0) && lz_q && (nib_s == 4'd0) && (dig_s < UNIT_DIG)) begin
            char_s = SYMBOL_SPACE;
        end else begin
            char_s = digit_char(nib_s);
        end
    end

    // sequencing of accept, conversion wait and character emission
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        lz_d      = lz_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        ovf_d     = ovf_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    state_d = CONV;
                    idx_d   = 3'd0;
                    lz_d    = 1'b1;
                    ovf_d   = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            CONV: begin
                if (done_s) begin
                    state_d = EMIT;
                    ovf_d   = bcd_ovf_s;
                end else begin
                    state_d = CONV;
                end
            end
            EMIT:    state_d = EMIT;
            default: state_d = IDLE;
        endcase
        if (emit_s) begin
            wr_en_d   = 1'b1;
            wr_addr_d = 6'(BASE_ADDR) + {3'b000, idx_q};
            wr_data_d = char_s;
            idx_d     = idx_q + 3'd1;
            if (!is_dot_s && (nib_s != 4'd0)) begin
                lz_d = 1'b0;
            end else begin
                lz_d = lz_q;
            end
            if (idx_q == LAST_IDX) begin
                state_d = IDLE;
            end else begin
                state_d = EMIT;
            end
        end else begin
            wr_en_d = 1'b0;
        end
    end

    // state and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= 3'd0;
            lz_q      <= 1'b1;
            wr_en_q   <= 1'b0;
            wr_addr_q <= 6'd0;
            wr_data_q <= 10'd0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            lz_q      <= lz_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            ovf_q     <= ovf_d;
        end
    end

endmodule

// File: tb/tb_disp_num_fmt.sv
// Bench for disp_num_fmt: four parameter variants driven from one directed/random sequence,
// expectations computed arithmetically from the decimal formatting rules.
module tb_disp_num_fmt;

    localparam int NU   = 4;
    localparam int P_VB = 11;
    localparam int P_DIG [NU] = '{4, 3, 4, 4};
    localparam int P_DP  [NU] = '{1, 1, 0, 0};
    localparam int P_BLZ [NU] = '{1, 1, 1, 0};

    localparam logic [9:0] C_SPACE = 10'h220;
    localparam logic [9:0] C_DOT   = 10'h22E;
    localparam logic [9:0] C_MINUS = 10'h22D;

    logic        clk;
    logic        rst;
    logic [10:0] val_a     [NU];
    logic        vld_a     [NU];
    logic        rdy_a     [NU];
    logic        wr_en_a   [NU];
    logic [5:0]  wr_addr_a [NU];
    logic [9:0]  wr_data_a [NU];
    logic        busy_a    [NU];
    logic        ovf_a     [NU];

    int tests = 0;
    int fails = 0;

    for (genvar g = 0; g < NU; g++) begin : g_dut
        disp_num_fmt #(
            .VAL_BITS  (P_VB),
            .DIGITS    (P_DIG[g]),
            .DP_POS    (P_DP[g]),
            .BLANK_LZ  (P_BLZ[g]),
            .BASE_ADDR (6)
        ) u_dut (
            .clk     (clk),
            .rst     (rst),
            .val     (val_a[g]),
            .val_vld (vld_a[g]),
            .val_rdy (rdy_a[g]),
            .wr_en   (wr_en_a[g]),
            .wr_addr (wr_addr_a[g]),
            .wr_data (wr_data_a[g]),
            .busy    (busy_a[g]),
            .ovf     (ovf_a[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int pow10(input int n);
        int r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    function automatic int nchr_of(input int u);
        return P_DIG[u] + ((P_DP[u] > 0) ? 1 : 0);
    endfunction

    // expected character k of the field showing v on unit u
    function automatic logic [9:0] exp_char(input int u, input int v, input int k);
        int d, dp, di, dig;
        d  = P_DIG[u];
        dp = P_DP[u];
        if (dp > 0 && k == d - dp) return C_DOT;
        di = (dp > 0 && k > d - dp) ? k - 1 : k;
        if (v > pow10(d) - 1) return C_MINUS;
        dig = (v / pow10(d - 1 - di)) % 10;
        if (P_BLZ[u] == 1 && di < d - dp - 1 && v < pow10(d - 1 - di)) return C_SPACE;
        return {2'b10, 8'(8'h30 + dig)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // one complete field on unit u: accept, timing, addresses, characters, ovf
    task automatic run_field(input int u, input int v);
        int nchr, got, c, lim;
        logic exp_ovf;
        nchr    = nchr_of(u);
        exp_ovf = (v > pow10(P_DIG[u]) - 1);
        c = 0;
        while (!rdy_a[u] && c < 100) begin
            @(negedge clk);
            c++;
        end
        check("rdy_before_accept", 32'(rdy_a[u]), 32'd1);
        @(negedge clk);
        val_a[u] = 11'(v);
        vld_a[u] = 1'b1;
        @(posedge clk);
        #1;
        vld_a[u] = 1'b0;
        check("busy_after_accept", 32'(busy_a[u]), 32'd1);
        check("ovf_cleared_on_accept", 32'(ovf_a[u]), 32'd0);
        got = 0;
        lim = P_VB + nchr + 4;
        for (c = 1; c <= lim && got < nchr; c++) begin
            @(posedge clk);
            #1;
            if (wr_en_a[u]) begin
                check("wr_cycle", 32'(c), 32'(P_VB + 1 + got));
                check("wr_addr", 32'(wr_addr_a[u]), 32'(6 + got));
                check("wr_data", 32'(wr_data_a[u]), 32'(exp_char(u, v, got)));
                if (got == 0) check("ovf_at_first_wr", 32'(ovf_a[u]), 32'(exp_ovf));
                got++;
            end
        end
        check("wr_count", 32'(got), 32'(nchr));
        check("rdy_after_last", 32'(rdy_a[u]), 32'd1);
        check("busy_after_last", 32'(busy_a[u]), 32'd0);
        @(posedge clk);
        #1;
        check("wr_en_drops", 32'(wr_en_a[u]), 32'd0);
        check("ovf_held", 32'(ovf_a[u]), 32'(exp_ovf));
    endtask

    int seen, quiet_bad, acc, cyc;
    int acc_cyc [2];
    bit pend;
    int       wc_q [$];
    logic [5:0] wa_q [$];
    logic [9:0] wd_q [$];

    initial begin
        rst = 1'b1;
        for (int i = 0; i < NU; i++) begin
            val_a[i] = 11'd0;
            vld_a[i] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        check("rst_wr_en", 32'(wr_en_a[0]), 32'd0);
        check("rst_wr_addr", 32'(wr_addr_a[0]), 32'd0);
        check("rst_wr_data", 32'(wr_data_a[0]), 32'd0);
        check("rst_busy", 32'(busy_a[0]), 32'd0);
        check("rst_ovf", 32'(ovf_a[0]), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rdy_after_release", 32'(rdy_a[0]), 32'd1);

        // directed fields
        run_field(0, 1207);
        run_field(0, 5);
        run_field(2, 0);
        run_field(3, 0);
        run_field(1, 2047);
        repeat (5) @(posedge clk);
        #1;
        check("ovf_held_idle", 32'(ovf_a[1]), 32'd1);
        run_field(1, 999);
        run_field(1, 1000);
        run_field(0, 9999 % 2048);
        run_field(3, 70);

        // back-to-back with val_vld held high
        @(negedge clk);
        val_a[0] = 11'd1207;
        vld_a[0] = 1'b1;
        acc = 0;
        cyc = 0;
        for (int c = 0; c < 60 && wc_q.size() < 10; c++) begin
            pend = rdy_a[0] && vld_a[0];
            @(posedge clk);
            #1;
            cyc++;
            if (pend) begin
                if (acc < 2) acc_cyc[acc] = cyc;
                acc++;
                if (acc == 1) val_a[0] = 11'd333;
                else vld_a[0] = 1'b0;
            end
            if (wr_en_a[0]) begin
                wc_q.push_back(cyc);
                wa_q.push_back(wr_addr_a[0]);
                wd_q.push_back(wr_data_a[0]);
            end
            @(negedge clk);
        end
        vld_a[0] = 1'b0;
        check("b2b_accepts", 32'(acc), 32'd2);
        check("b2b_period", 32'(acc_cyc[1] - acc_cyc[0]), 32'(P_VB + 5 + 1));
        check("b2b_writes", 32'(wc_q.size()), 32'd10);
        for (int k = 0; k < wc_q.size() && k < 10; k++) begin
            check("b2b_cycle", 32'(wc_q[k]), 32'(acc_cyc[k / 5] + P_VB + 1 + (k % 5)));
            check("b2b_addr", 32'(wa_q[k]), 32'(6 + (k % 5)));
            check("b2b_data", 32'(wd_q[k]), 32'(exp_char(0, (k < 5) ? 1207 : 333, k % 5)));
        end
        repeat (3) @(posedge clk);

        // reset during the third emitted character
        @(negedge clk);
        val_a[0] = 11'd1207;
        vld_a[0] = 1'b1;
        @(posedge clk);
        #1;
        vld_a[0] = 1'b0;
        seen = 0;
        for (int c = 0; c < 40 && seen < 3; c++) begin
            @(posedge clk);
            #1;
            if (wr_en_a[0]) seen++;
        end
        check("mid_emit_reached", 32'(seen), 32'd3);
        #1 rst = 1'b1;
        #1;
        check("arst_wr_en", 32'(wr_en_a[0]), 32'd0);
        check("arst_wr_addr", 32'(wr_addr_a[0]), 32'd0);
        check("arst_wr_data", 32'(wr_data_a[0]), 32'd0);
        check("arst_busy", 32'(busy_a[0]), 32'd0);
        check("arst_rdy", 32'(rdy_a[0]), 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        quiet_bad = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (wr_en_a[0] || busy_a[0]) quiet_bad++;
        end
        check("no_writes_after_reset", 32'(quiet_bad), 32'd0);
        run_field(0, 1207);

        // randomized fields across all variants
        for (int i = 0; i < 24; i++) begin
            run_field(i % NU, (i % 3 == 0) ? int'($urandom_range(0, 20)) : int'($urandom_range(0, 2047)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
